// File: rtl/spi_slave_responder_pkg.sv
// Shared state encoding and default opcodes for the SPI mode-0 register responder.
// Opcode 0x0D (FIFO read) is reserved and deliberately decodes as an unknown command.
package spi_slave_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR_W = 3'd2,
        ST_ADDR_R = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    localparam int         SYNC_STAGES_DEF = 2;
    localparam logic [7:0] CMD_WRITE_DEF   = 8'h0A;
    localparam logic [7:0] CMD_READ_DEF    = 8'h0B;
    localparam logic [7:0] CMD_FIFO_READ   = 8'h0D;

    // Register address auto-increment; 0xFF wraps to 0x00.
    function automatic logic [7:0] addr_inc(input logic [7:0] addr);
        return addr + 8'd1;
    endfunction

endpackage

// File: rtl/spi_slave_responder_sync.sv
// Pad synchronizers for sck/ncs/mosi plus edge detection on the synchronized sck and ncs.
// mosi is taken from the same stage as sck so the bit is aligned with the rising edge.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sck,
    input  logic i_ncs,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ncs_level,
    output logic o_ncs_fall,
    output logic o_mosi_s
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_ncs_d;

    // Synchronizer chains and one-cycle-delayed copies for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck_sync  <= '0;
            r_ncs_sync  <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], i_ncs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_ncs_d     <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign o_sck_rise  = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
    assign o_sck_fall  = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
    assign o_ncs_level = r_ncs_sync[SYNC_STAGES-1];
    assign o_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-1] & r_ncs_d;
    assign o_mosi_s    = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target answering the ADXL362 write/read-register commands and
// fronting an 8-bit register bus with address auto-increment.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       ncs_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic       cmd_err_o
);

    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_ncs_level;
    logic       w_ncs_fall;
    logic       w_mosi;
    logic       w_byte_done;
    logic [7:0] w_byte;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [6:0] r_tx_shift;
    logic       r_miso;
    logic       r_miso_oe;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_re;
    logic       r_cmd_err;
    logic       r_busy;
    logic       r_re_pend;
    logic       r_load_pend;
    logic       r_inc_pend;

    state_t     w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [6:0] w_rx_shift_nxt;
    logic [6:0] w_tx_shift_nxt;
    logic       w_miso_nxt;
    logic       w_miso_oe_nxt;
    logic [7:0] w_addr_nxt;
    logic [7:0] w_wdata_nxt;
    logic       w_we_nxt;
    logic       w_re_nxt;
    logic       w_cmd_err_nxt;
    logic       w_re_pend_nxt;
    logic       w_load_pend_nxt;
    logic       w_inc_pend_nxt;

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_sck       (sck_i),
        .i_ncs       (ncs_i),
        .i_mosi      (mosi_i),
        .o_sck_rise  (w_sck_rise),
        .o_sck_fall  (w_sck_fall),
        .o_ncs_level (w_ncs_level),
        .o_ncs_fall  (w_ncs_fall),
        .o_mosi_s    (w_mosi)
    );

    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_rx_shift, w_mosi};

    // Next-state and next-output decode; chip-select deassertion overrides everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_rx_shift_nxt  = r_rx_shift;
        w_tx_shift_nxt  = r_tx_shift;
        w_miso_nxt      = r_miso;
        w_miso_oe_nxt   = r_miso_oe;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_we_nxt        = 1'b0;
        w_re_nxt        = 1'b0;
        w_cmd_err_nxt   = 1'b0;
        w_re_pend_nxt   = 1'b0;
        w_load_pend_nxt = 1'b0;
        w_inc_pend_nxt  = 1'b0;

        if (r_inc_pend) begin
            w_addr_nxt = addr_inc(r_addr);
        end else begin
            w_addr_nxt = r_addr;
        end

        if (w_ncs_level) begin
            w_state_nxt   = ST_IDLE;
            w_miso_oe_nxt = 1'b0;
            w_bit_cnt_nxt = 3'd0;
        end else begin
            if (w_sck_rise) begin
                w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                w_rx_shift_nxt = w_byte[6:0];
            end else begin
                w_bit_cnt_nxt  = r_bit_cnt;
            end
            w_load_pend_nxt = r_re;

            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall) begin
                        w_state_nxt   = ST_CMD;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (w_byte_done) begin
                        if (w_byte == CMD_WRITE) begin
                            w_state_nxt = ST_ADDR_W;
                        end else if (w_byte == CMD_READ) begin
                            w_state_nxt = ST_ADDR_R;
                        end else begin
                            w_state_nxt   = ST_IGNORE;
                            w_cmd_err_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_CMD;
                    end
                end
                ST_ADDR_W: begin
                    if (w_byte_done) begin
                        w_addr_nxt  = w_byte;
                        w_state_nxt = ST_WDATA;
                    end else begin
                        w_state_nxt = ST_ADDR_W;
                    end
                end
                ST_ADDR_R: begin
                    if (w_byte_done) begin
                        w_addr_nxt  = w_byte;
                        w_re_nxt    = 1'b1;
                        w_state_nxt = ST_RDATA;
                    end else begin
                        w_state_nxt = ST_ADDR_R;
                    end
                end
                ST_WDATA: begin
                    if (w_byte_done) begin
                        w_wdata_nxt    = w_byte;
                        w_we_nxt       = 1'b1;
                        w_inc_pend_nxt = 1'b1;
                    end else begin
                        w_wdata_nxt    = r_wdata;
                    end
                end
                ST_RDATA: begin
                    w_re_nxt = r_re_pend;
                    // The fall right after a byte boundary must not shift: bit7 is already loaded.
                    if (r_load_pend) begin
                        w_tx_shift_nxt = reg_rdata_i[6:0];
                        w_miso_nxt     = reg_rdata_i[7];
                        w_miso_oe_nxt  = 1'b1;
                    end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
                        w_tx_shift_nxt = {r_tx_shift[5:0], 1'b0};
                        w_miso_nxt     = r_tx_shift[6];
                    end else begin
                        w_tx_shift_nxt = r_tx_shift;
                    end
                    if (w_byte_done) begin
                        w_addr_nxt    = addr_inc(r_addr);
                        w_re_pend_nxt = 1'b1;
                    end else begin
                        w_re_pend_nxt = 1'b0;
                    end
                end
                ST_IGNORE: begin
                    w_miso_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_miso_oe_nxt = 1'b0;
                    w_bit_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 7'd0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_re_pend   <= 1'b0;
            r_load_pend <= 1'b0;
            r_inc_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_miso      <= w_miso_nxt;
            r_miso_oe   <= w_miso_oe_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_we        <= w_we_nxt;
            r_re        <= w_re_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_re_pend   <= w_re_pend_nxt;
            r_load_pend <= w_load_pend_nxt;
            r_inc_pend  <= w_inc_pend_nxt;
        end
    end

    assign miso_o      = r_miso;
    assign miso_oe_o   = r_miso_oe;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_we_o    = r_we;
    assign reg_re_o    = r_re;
    assign busy_o      = r_busy;
    assign cmd_err_o   = r_cmd_err;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench: an SPI master task drives the pads at SCLK = clk/8, a bus model
// answers reads, and bus strobes are checked against queued expectations.
module tb_spi_slave_responder;

    localparam int SYNC = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sck_i;
    logic       ncs_i;
    logic       mosi_i;
    logic       miso_o;
    logic       miso_oe_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i = 8'h00;
    logic       busy_o;
    logic       cmd_err_o;

    int total = 0;
    int bad   = 0;
    logic rd_mode = 1'b0;

    logic [15:0] obs_we [0:63];
    logic [7:0]  obs_re [0:63];
    int obs_we_n = 0;
    int obs_re_n = 0;
    int err_total = 0;
    int oe_total = 0;
    int both_total = 0;
    int rd_we = 0;
    int rd_re = 0;

    logic [15:0] exp_we_q[$];
    logic [7:0]  exp_re_q[$];

    spi_slave_responder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sck_i       (sck_i),
        .ncs_i       (ncs_i),
        .mosi_i      (mosi_i),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .cmd_err_o   (cmd_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Register-bus model: read data appears the cycle after the read strobe.
    always @(posedge clk_i) begin
        if (reg_re_o) begin
            reg_rdata_i <= rd_mode ? (reg_addr_o ^ 8'h55) : 8'hAD;
        end
    end

    // Bus monitor: records every strobe away from the active edge.
    always @(negedge clk_i) begin
        if (reg_we_o) begin
            obs_we[obs_we_n] <= {reg_addr_o, reg_wdata_o};
            obs_we_n <= obs_we_n + 1;
        end
        if (reg_re_o) begin
            obs_re[obs_re_n] <= reg_addr_o;
            obs_re_n <= obs_re_n + 1;
        end
        if (cmd_err_o)            err_total  <= err_total + 1;
        if (miso_oe_o)            oe_total   <= oe_total + 1;
        if (reg_we_o && reg_re_o) both_total <= both_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        logic [15:0] e16;
        logic [15:0] o16;
        logic [7:0]  e8;
        logic [7:0]  o8;
        while (exp_we_q.size() > 0) begin
            e16 = exp_we_q.pop_front();
            o16 = (rd_we < obs_we_n) ? obs_we[rd_we] : 16'hxxxx;
            rd_we++;
            chk({tag, "_we"}, {16'h0000, o16}, {16'h0000, e16});
        end
        chk({tag, "_we_count"}, obs_we_n, rd_we);
        rd_we = obs_we_n;
        while (exp_re_q.size() > 0) begin
            e8 = exp_re_q.pop_front();
            o8 = (rd_re < obs_re_n) ? obs_re[rd_re] : 8'hxx;
            rd_re++;
            chk({tag, "_re_addr"}, {24'h0, o8}, {24'h0, e8});
        end
        chk({tag, "_re_count"}, obs_re_n, rd_re);
        rd_re = obs_re_n;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_i = tx[7-i];
            #40;
            rx[7-i] = miso_o;
            sck_i = 1'b1;
            #40;
            sck_i = 1'b0;
        end
    endtask

    task automatic cs_start();
        @(negedge clk_i);
        ncs_i = 1'b0;
        #40;
    endtask

    task automatic cs_end(input string tag);
        #40;
        chk({tag, "_busy_before_ncs"}, {31'd0, busy_o}, 32'd1);
        ncs_i = 1'b1;
        repeat (SYNC + 2) @(negedge clk_i);
        chk({tag, "_busy_after_ncs"}, {31'd0, busy_o}, 32'd0);
        #100;
    endtask

    initial begin
        logic [7:0] rx;
        int oe0;
        int err0;
        rst_i = 1'b1; sck_i = 1'b0; ncs_i = 1'b1; mosi_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("rst_bus", {8'h0, reg_addr_o, reg_wdata_o, 6'd0, reg_we_o, reg_re_o}, 32'd0);
        chk("rst_misc", {28'd0, miso_o, miso_oe_o, busy_o, cmd_err_o}, 32'd0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Single write 0A 2D 02.
        oe0 = oe_total;
        exp_we_q.push_back({8'h2D, 8'h02});
        cs_start();
        spi_xfer(8'h0A, 8, rx); spi_xfer(8'h2D, 8, rx); spi_xfer(8'h02, 8, rx);
        cs_end("wr1");
        check_events("wr1");
        chk("wr1_oe_quiet", oe_total - oe0, 32'd0);

        // Single read at 0x00, model returns 0xAD.
        rd_mode = 1'b0;
        exp_re_q.push_back(8'h00); exp_re_q.push_back(8'h01);
        cs_start();
        spi_xfer(8'h0B, 8, rx); spi_xfer(8'h00, 8, rx); spi_xfer(8'hFF, 8, rx);
        chk("rd1_data", {24'h0, rx}, 32'hAD);
        cs_end("rd1");
        check_events("rd1");

        // Burst read from 0xFE with address wrap, data = addr ^ 0x55.
        rd_mode = 1'b1;
        exp_re_q.push_back(8'hFE); exp_re_q.push_back(8'hFF);
        exp_re_q.push_back(8'h00); exp_re_q.push_back(8'h01);
        cs_start();
        spi_xfer(8'h0B, 8, rx); spi_xfer(8'hFE, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("brd_b0", {24'h0, rx}, 32'hAB);
        spi_xfer(8'h00, 8, rx); chk("brd_b1", {24'h0, rx}, 32'hAA);
        spi_xfer(8'h00, 8, rx); chk("brd_b2", {24'h0, rx}, 32'h55);
        cs_end("brd");
        check_events("brd");

        // Burst write then abort mid-byte: partial byte must not write.
        exp_we_q.push_back({8'h10, 8'h11}); exp_we_q.push_back({8'h11, 8'h22});
        cs_start();
        spi_xfer(8'h0A, 8, rx); spi_xfer(8'h10, 8, rx);
        spi_xfer(8'h11, 8, rx); spi_xfer(8'h22, 8, rx); spi_xfer(8'h33, 4, rx);
        cs_end("bwr");
        check_events("bwr");
        chk("bwr_wdata_hold", {24'h0, reg_wdata_o}, 32'h22);

        // Unknown opcode, then a normal read.
        oe0 = oe_total; err0 = err_total;
        cs_start();
        spi_xfer(8'h55, 8, rx); spi_xfer(8'h00, 8, rx); spi_xfer(8'hFF, 8, rx);
        cs_end("bad");
        check_events("bad");
        chk("bad_err_pulses", err_total - err0, 32'd1);
        chk("bad_oe_quiet", oe_total - oe0, 32'd0);
        exp_re_q.push_back(8'h00); exp_re_q.push_back(8'h01);
        cs_start();
        spi_xfer(8'h0B, 8, rx); spi_xfer(8'h00, 8, rx); spi_xfer(8'h00, 8, rx);
        chk("after_bad_data", {24'h0, rx}, 32'h55);
        cs_end("after_bad");
        check_events("after_bad");

        // Reset during the data phase of a read.
        exp_re_q.push_back(8'h20);
        cs_start();
        spi_xfer(8'h0B, 8, rx); spi_xfer(8'h20, 8, rx); spi_xfer(8'h00, 4, rx);
        chk("mid_oe_active", {31'd0, miso_oe_o}, 32'd1);
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0;
        chk("mrst_bus", {8'h0, reg_addr_o, reg_wdata_o, 6'd0, reg_we_o, reg_re_o}, 32'd0);
        chk("mrst_misc", {28'd0, miso_o, miso_oe_o, busy_o, cmd_err_o}, 32'd0);
        oe0 = oe_total;
        spi_xfer(8'h00, 4, rx); spi_xfer(8'h0B, 8, rx); spi_xfer(8'h00, 8, rx);
        chk("mrst_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("mrst_idle_oe", oe_total - oe0, 32'd0);
        ncs_i = 1'b1;
        #100;
        check_events("mrst");
        exp_re_q.push_back(8'h07); exp_re_q.push_back(8'h08);
        cs_start();
        spi_xfer(8'h0B, 8, rx); spi_xfer(8'h07, 8, rx); spi_xfer(8'h00, 8, rx);
        chk("post_rst_data", {24'h0, rx}, 32'h52);
        cs_end("post_rst");
        check_events("post_rst");

        chk("we_re_exclusive", both_total, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
